seg_scan_arbiter: RTL

Time-multiplexed scan controller for the 4-digit common-ground 7-segment display. It shares the display between two requesters: client 0 is the base counter value and client 1 is a priority overlay, such as a status or error code. It owns digit scan timing, anti-ghosting dead time, scan-rate selection and frame-coherent value snapshots, and drives the display and grounds pins directly.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_scan_arbiter_if.sv | 23 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, scan states and client indices for the seven-segment scan arbiter
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} patterns indexed by hex digit value
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DEAD  = DEAD;
    localparam logic [1:0] ST_DRIVE = DRIVE;

    localparam int CLIENT_BASE    = 0;
    localparam int CLIENT_OVERLAY = 1;

    localparam logic [1:0] GNT_NONE    = 2'b00;
    localparam logic [1:0] GNT_BASE    = 2'b01;
    localparam logic [1:0] GNT_OVERLAY = 2'b10;

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// rtl/seg_scan_arbiter_if.sv - request/value/display bundle between the clients and the scan arbiter
interface seg_scan_arbiter_if;

    logic [1:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [1:0]  rate_sel;
    logic [1:0]  gnt;
    logic [6:0]  display;
    logic [3:0]  grounds;
    logic        frame_done;

    modport master (
        output req, val0, val1, rate_sel,
        input  gnt, display, grounds, frame_done
    );

    modport slave (
        input  req, val0, val1, rate_sel,
        output gnt, display, grounds, frame_done
    );

endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low seven-segment pattern
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_arbiter.sv
// rtl/seg_scan_arbiter.sv - two-client 4-digit 7-segment scan controller; LZ_BLANK_EN enables leading-zero blanking
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int DIV_SHIFT0  = 15,
    parameter int DIV_SHIFT1  = 19,
    parameter int DIV_SHIFT2  = 25,
    parameter int DEAD_CYCLES = 64,
    parameter int MIN_FRAMES  = 4
)
(
    input  logic             clk,
    input  logic             rst,
    seg_scan_arbiter_if.slave bus
);

    localparam int MAX01     = (DIV_SHIFT0 > DIV_SHIFT1) ? DIV_SHIFT0 : DIV_SHIFT1;
    localparam int MAX_SHIFT = (MAX01 > DIV_SHIFT2) ? MAX01 : DIV_SHIFT2;
    localparam int MIN01     = (DIV_SHIFT0 < DIV_SHIFT1) ? DIV_SHIFT0 : DIV_SHIFT1;
    localparam int MIN_SHIFT = (MIN01 < DIV_SHIFT2) ? MIN01 : DIV_SHIFT2;
    localparam int CW        = MAX_SHIFT;
    localparam int FW        = $clog2(MIN_FRAMES + 1);

    localparam logic [CW-1:0] LAST0    = CW'((64'd1 << DIV_SHIFT0) - 64'd1);
    localparam logic [CW-1:0] LAST1    = CW'((64'd1 << DIV_SHIFT1) - 64'd1);
    localparam logic [CW-1:0] LAST2    = CW'((64'd1 << DIV_SHIFT2) - 64'd1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);
    localparam logic [FW-1:0] MIN_F    = FW'(MIN_FRAMES);
    localparam logic [FW-1:0] FMAX     = {FW{1'b1}};

    generate
        if (DEAD_CYCLES >= (1 << MIN_SHIFT)) begin : g_bad_dead
            $error("DEAD_CYCLES must be shorter than the shortest digit slot");
        end
    endgenerate

    logic [1:0]    state_q, nxt_state;
    logic [1:0]    digit_q, nxt_digit;
    logic [CW-1:0] cnt_q, nxt_cnt;
    logic [1:0]    rate_q, nxt_rate;
    logic [15:0]   snap_q, nxt_snap;
    logic [1:0]    gnt_q, nxt_gnt;
    logic [FW-1:0] fcnt_q, nxt_fcnt;
    logic [6:0]    display_q, nxt_display;
    logic [3:0]    grounds_q, nxt_grounds;
    logic          frame_done_q, nxt_frame_done;

    logic [1:0]    arb_gnt;
    logic          frame_end;
    logic          take_frame;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;
    logic          lz_blank;

    // rate_sel==3 deliberately falls back to the fastest rate
    function automatic logic [CW-1:0] slot_last(input logic [1:0] rs);
        case (rs)
            2'd1:    slot_last = LAST1;
            2'd2:    slot_last = LAST2;
            default: slot_last = LAST0;
        endcase
    endfunction

    always_comb begin
        arb_gnt = gnt_q;
        case (gnt_q)
            GNT_OVERLAY: begin
                if (!bus.req[CLIENT_OVERLAY])
                    arb_gnt = bus.req[CLIENT_BASE] ? GNT_BASE : GNT_NONE;
            end
            GNT_BASE: begin
                if (!bus.req[CLIENT_BASE])
                    arb_gnt = bus.req[CLIENT_OVERLAY] ? GNT_OVERLAY : GNT_NONE;
                else if (bus.req[CLIENT_OVERLAY] && (fcnt_q >= MIN_F))
                    arb_gnt = GNT_OVERLAY;
            end
            default: begin
                if (bus.req[CLIENT_OVERLAY])
                    arb_gnt = GNT_OVERLAY;
                else if (bus.req[CLIENT_BASE])
                    arb_gnt = GNT_BASE;
                else
                    arb_gnt = GNT_NONE;
            end
        endcase
    end

    assign frame_end  = (state_q != ST_IDLE) && (digit_q == 2'd3) && (cnt_q == slot_last(rate_q));
    assign take_frame = frame_end || ((state_q == ST_IDLE) && (arb_gnt != GNT_NONE));

    always_comb begin
        nxt_state = state_q;
        nxt_digit = digit_q;
        nxt_cnt   = cnt_q;
        nxt_rate  = rate_q;
        nxt_snap  = snap_q;
        nxt_gnt   = gnt_q;
        nxt_fcnt  = fcnt_q;

        if (take_frame) begin
            // Snapshot, rate and owner only move here so a frame never mixes values
            nxt_gnt   = arb_gnt;
            nxt_rate  = bus.rate_sel;
            nxt_snap  = (arb_gnt == GNT_OVERLAY) ? bus.val1 : bus.val0;
            nxt_digit = 2'd0;
            nxt_cnt   = '0;
            nxt_state = (arb_gnt == GNT_NONE) ? ST_IDLE : ST_DEAD;
            if (arb_gnt != gnt_q)
                nxt_fcnt = '0;
            else if (fcnt_q != FMAX)
                nxt_fcnt = fcnt_q + 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == slot_last(rate_q)) begin
                nxt_digit = digit_q + 2'd1;
                nxt_cnt   = '0;
            end else begin
                nxt_cnt = cnt_q + 1'b1;
            end
        end

        if (nxt_state != ST_IDLE)
            nxt_state = (nxt_cnt < DEAD_CNT) ? ST_DEAD : ST_DRIVE;
    end

    always_comb begin
        case (nxt_digit)
            2'd0:    nibble = nxt_snap[15:12];
            2'd1:    nibble = nxt_snap[11:8];
            2'd2:    nibble = nxt_snap[7:4];
            default: nibble = nxt_snap[3:0];
        endcase
    end

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef LZ_BLANK_EN
    // The rightmost digit is always shown so an all-zero value reads as "0"
    always_comb begin
        case (nxt_digit)
            2'd0:    lz_blank = (nxt_snap[15:12] == 4'h0);
            2'd1:    lz_blank = (nxt_snap[15:8] == 8'h00);
            2'd2:    lz_blank = (nxt_snap[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Outputs are computed from next-state so pins move together with the FSM
    always_comb begin
        nxt_grounds    = (nxt_state == ST_DRIVE) ? (4'b0001 << nxt_digit) : 4'b0000;
        nxt_display    = ((nxt_state == ST_DRIVE) && !lz_blank) ? dec_seg : SEG_BLANK;
        nxt_frame_done = (nxt_state != ST_IDLE) && (nxt_digit == 2'd3)
                         && (nxt_cnt == slot_last(nxt_rate));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            rate_q       <= 2'd0;
            snap_q       <= 16'h0000;
            gnt_q        <= GNT_NONE;
            fcnt_q       <= '0;
            display_q    <= SEG_BLANK;
            grounds_q    <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= nxt_state;
            digit_q      <= nxt_digit;
            cnt_q        <= nxt_cnt;
            rate_q       <= nxt_rate;
            snap_q       <= nxt_snap;
            gnt_q        <= nxt_gnt;
            fcnt_q       <= nxt_fcnt;
            display_q    <= nxt_display;
            grounds_q    <= nxt_grounds;
            frame_done_q <= nxt_frame_done;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.display    = display_q;
    assign bus.grounds    = grounds_q;
    assign bus.frame_done = frame_done_q;

endmodule
